// File: rtl/npu_mem_pkg.sv
// Shared definitions for the NPU memory scheduler: FSM states and host register map.
package npu_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN,
        DONE
    } state_e;

    localparam logic [1:0] REG_DATA = 2'd0;
    localparam logic [1:0] REG_LEN  = 2'd1;
    localparam logic [1:0] REG_CMD  = 2'd2;

    localparam int unsigned CMD_START = 0;
    localparam int unsigned CMD_CLR   = 1;

endpackage

// File: rtl/npu_rd_pipe.sv
// Read-return pipe: tracks in-flight RAM reads and registers each returning word
// into the four stream byte lanes.
module npu_rd_pipe #(
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_i,
    input  logic [DATA_W-1:0] rdata_i,
    output logic [7:0]        data0_o,
    output logic [7:0]        data1_o,
    output logic [7:0]        data2_o,
    output logic [7:0]        data3_o,
    output logic              valid_o,
    output logic              pending_o
);

    logic [RD_LAT-1:0] vld_q;
    logic [DATA_W-1:0] beat_q;
    logic              valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q   <= '0;
            beat_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            vld_q[0] <= issue_i;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
            valid_q <= vld_q[RD_LAT-1];
            // Bytes are only updated by a real beat so they hold between beats.
            if (vld_q[RD_LAT-1]) begin
                beat_q <= rdata_i;
            end
        end
    end

    assign data0_o   = beat_q[31:24];
    assign data1_o   = beat_q[23:16];
    assign data2_o   = beat_q[15:8];
    assign data3_o   = beat_q[7:0];
    assign valid_o   = valid_q;
    assign pending_o = |vld_q;

endmodule

// File: rtl/npu_mem_sched.sv
// Owns the single-port NPU RAM: host Avalon loads in IDLE, PE-array read stream
// otherwise, with the host stalled through waitrequest until the stream completes.
module npu_mem_sched
    import npu_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              chipselect,
    input  logic              write,
    input  logic [1:0]        address,
    input  logic [31:0]       writedata,
    output logic              waitrequest,
    input  logic              reading,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [7:0]        data0,
    output logic [7:0]        data1,
    output logic [7:0]        data2,
    output logic [7:0]        data3,
    output logic              data_valid,
    output logic              busy,
    output logic              done
);

    state_e            state_q;
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W-1:0] rd_ptr_q;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   issued_q;
    logic [ADDR_W:0]   issued_d;
    logic              busy_q;
    logic              done_q;
    logic              host_wr;
    logic              accept;
    logic              issue;
    logic              pipe_pending;

    always_comb begin
        host_wr     = chipselect & write;
        accept      = host_wr & (state_q == IDLE);
        waitrequest = host_wr & (state_q != IDLE);
        ram_we      = accept & (address == REG_DATA);
        ram_wdata   = ram_we ? writedata : '0;
        ram_addr    = (state_q == IDLE) ? wr_ptr_q : rd_ptr_q;
        issue       = (state_q == STREAM) & reading;
        issued_d    = issued_q + (ADDR_W+1)'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            len_q    <= '0;
            issued_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        case (address)
                            REG_DATA: wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
                            REG_LEN:  len_q    <= writedata[ADDR_W:0];
                            REG_CMD: begin
                                if (writedata[CMD_CLR]) begin
                                    wr_ptr_q <= '0;
                                end
                                if (writedata[CMD_START]) begin
                                    if (len_q == '0) begin
                                        state_q <= DONE;
                                        done_q  <= 1'b1;
                                    end else begin
                                        rd_ptr_q <= '0;
                                        issued_q <= '0;
                                        busy_q   <= 1'b1;
                                        state_q  <= STREAM;
                                    end
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                STREAM: begin
                    if (reading) begin
                        rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
                        issued_q <= issued_d;
                        if (issued_d == len_q) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Pipe empty with a beat on the outputs means the final beat is showing now.
                    if (!pipe_pending && data_valid) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;

    npu_rd_pipe #(
        .RD_LAT (RD_LAT),
        .DATA_W (DATA_W)
    ) u_rd_pipe (
        .clk       (clk),
        .rst       (reset),
        .issue_i   (issue),
        .rdata_i   (ram_rdata),
        .data0_o   (data0),
        .data1_o   (data1),
        .data2_o   (data2),
        .data3_o   (data3),
        .valid_o   (data_valid),
        .pending_o (pipe_pending)
    );

endmodule

// File: tb/tb_npu_mem_sched.sv
// Directed + randomized bench for npu_mem_sched: RAM behavioural model, host-side
// shadow memory and an issue/beat timing model derived from the stream rules.
module tb_npu_mem_sched;
    import npu_mem_pkg::*;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 32;
    localparam int RD_LAT = 1;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int BOUND  = 200;

    logic              clk = 1'b0;
    logic              reset;
    logic              chipselect;
    logic              write;
    logic [1:0]        address;
    logic [31:0]       writedata;
    logic              waitrequest;
    logic              reading;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic [7:0]        data0, data1, data2, data3;
    logic              data_valid;
    logic              busy;
    logic              done;

    logic [31:0] mem     [DEPTH]  = '{default: '0};
    logic [31:0] exp_mem [DEPTH]  = '{default: '0};
    logic [31:0] rpipe   [RD_LAT] = '{default: '0};

    int cyc   = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int wp    = 0;
    logic [31:0] got_w[$];
    int          got_c[$];
    int          done_c[$];

    npu_mem_sched #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .chipselect  (chipselect),
        .write       (write),
        .address     (address),
        .writedata   (writedata),
        .waitrequest (waitrequest),
        .reading     (reading),
        .ram_addr    (ram_addr),
        .ram_we      (ram_we),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata),
        .data0       (data0),
        .data1       (data1),
        .data2       (data2),
        .data3       (data3),
        .data_valid  (data_valid),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Single-port RAM with RD_LAT-cycle registered read.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_we) mem[ram_addr] <= ram_wdata;
        rpipe[0] <= mem[ram_addr];
        for (int i = 1; i < RD_LAT; i++) rpipe[i] <= rpipe[i-1];
    end
    assign ram_rdata = rpipe[RD_LAT-1];

    always @(negedge clk) begin
        if (!reset) begin
            if (data_valid) begin
                got_w.push_back({data0, data1, data2, data3});
                got_c.push_back(cyc);
            end
            if (done) done_c.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outs(input string tag);
        check({tag, "_ctl"}, {waitrequest, ram_we, ram_addr, data_valid, busy, done}, '0);
        check({tag, "_dat"}, {ram_wdata, data0, data1, data2, data3}, '0);
    endtask

    task automatic host_write(input logic [1:0] a, input logic [31:0] d, input bit chk);
        int n = 0;
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        #1;
        while (waitrequest && n < BOUND) begin
            @(posedge clk); #1;
            n++;
        end
        if (waitrequest) check("host_write_timeout", waitrequest, 0);
        if (a == REG_DATA) begin
            if (chk) begin
                check("wr_addr", {ram_we, ram_addr}, {1'b1, ADDR_W'(wp)});
                check("wr_data", ram_wdata, d);
            end
            exp_mem[wp] = d;
            wp = (wp + 1) % DEPTH;
        end else if (a == REG_CMD && d[1]) begin
            wp = 0;
        end
        @(posedge clk); #1;
        chipselect = 1'b0; write = 1'b0;
    endtask

    // Called in the first cycle after the start command was accepted.
    task automatic run_stream(input int len, input bit toggle, input bit hostwr, input logic [31:0] hd);
        int a, nis, n, bad_stall, we_seen, exp_done, m;
        int exp_c[$];
        a = cyc; nis = 0; n = 0; bad_stall = 0; we_seen = 0;
        if (hostwr) begin
            chipselect = 1'b1; write = 1'b1; address = REG_DATA; writedata = hd;
        end
        check("busy_at_start", busy, len != 0);
        while (done_c.size() == 0 && n < 4 * len + 40) begin
            reading = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
            if (reading && nis < len) begin
                exp_c.push_back(cyc + RD_LAT + 1);
                nis++;
            end
            #1;
            if (hostwr && !waitrequest) bad_stall++;
            if (ram_we) we_seen++;
            @(posedge clk); #1;
            n++;
        end
        reading = 1'b0;
        check("done_seen", done_c.size(), 1);
        exp_done = (len == 0) ? a : ((exp_c.size() > 0) ? exp_c[exp_c.size()-1] + 1 : -1);
        if (done_c.size() > 0) check("done_cycle", done_c[0], exp_done);
        check("beat_count", got_w.size(), len);
        m = (got_w.size() < exp_c.size()) ? got_w.size() : exp_c.size();
        for (int k = 0; k < m; k++) begin
            check($sformatf("beat%0d_data", k), got_w[k], exp_mem[k]);
            check($sformatf("beat%0d_cycle", k), got_c[k], exp_c[k]);
        end
        check("busy_after_done", busy, 0);
        check("ram_we_outside_idle", we_seen, 0);
        if (hostwr) begin
            check("host_stall_held", bad_stall, 0);
            check("ram_untouched_before_accept", mem[wp], exp_mem[wp]);
            check("host_accept_we", {waitrequest, ram_we}, 2'b01);
            check("host_accept_addr", ram_addr, wp);
            @(posedge clk); #1;
            chipselect = 1'b0; write = 1'b0;
            exp_mem[wp] = hd;
            check("host_word_written", mem[wp], hd);
            wp = (wp + 1) % DEPTH;
        end
        repeat (3) begin @(posedge clk); #1; end
        check("single_done", done_c.size(), 1);
        check("no_extra_beats", got_w.size(), len);
    endtask

    task automatic stream(input logic [31:0] cmd, input int len, input bit toggle,
                          input bit hostwr, input logic [31:0] hd);
        got_w.delete(); got_c.delete(); done_c.delete();
        host_write(REG_CMD, cmd, 1'b1);
        run_stream(len, toggle, hostwr, hd);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] last;
        int nbeats;
        reset = 1'b1; chipselect = 1'b0; write = 1'b0; address = '0; writedata = '0; reading = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outs("reset");
        reset = 1'b0;

        // Reset in the middle of a load restarts the write pointer.
        for (int i = 0; i < 3; i++) host_write(REG_DATA, 32'hA000_0000 + i, 1'b1);
        reset = 1'b1; #1;
        check_idle_outs("reset_midload");
        @(posedge clk); #1;
        reset = 1'b0; wp = 0;
        host_write(REG_DATA, 32'h5555_AAAA, 1'b1);

        // Load 11 words and stream them with the consumer always ready.
        host_write(REG_CMD, 32'h2, 1'b1);
        for (int i = 0; i < 11; i++) host_write(REG_DATA, 32'h0103_0710 + i, 1'b1);
        host_write(REG_LEN, 32'd11, 1'b1);
        stream(32'h1, 11, 1'b0, 1'b0, '0);
        check("first_beat", exp_mem[0], 32'h0103_0710);
        check("last_beat_model", got_w.size() == 11 ? got_w[10] : 32'hX, 32'h0103_071A);

        // Same stream with a randomly throttled consumer.
        stream(32'h1, 11, 1'b1, 1'b0, '0);

        // Host write issued during a stream is held off and lands at wr_ptr 11.
        stream(32'h1, 11, 1'b1, 1'b1, 32'hDEAD_BEEF);

        // Zero-length stream completes immediately.
        host_write(REG_LEN, 32'd0, 1'b1);
        stream(32'h1, 0, 1'b0, 1'b0, '0);

        // Write pointer wrap, then combined clear+start.
        host_write(REG_CMD, 32'h2, 1'b1);
        last = '0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            last = $urandom;
            host_write(REG_DATA, last, 1'b0);
        end
        check("wrap_word0", mem[0], last);
        host_write(REG_DATA, $urandom, 1'b1);
        host_write(REG_LEN, 32'd4, 1'b1);
        stream(32'h3, 4, 1'b1, 1'b0, '0);
        host_write(REG_DATA, $urandom, 1'b1);

        // Reset during a stream aborts without a done pulse.
        host_write(REG_LEN, 32'd6, 1'b1);
        got_w.delete(); got_c.delete(); done_c.delete();
        host_write(REG_CMD, 32'h1, 1'b1);
        reading = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        reset = 1'b1; #1;
        check_idle_outs("reset_midstream");
        nbeats = got_w.size();
        @(posedge clk); #1;
        reset = 1'b0; reading = 1'b0; wp = 0;
        repeat (6) begin @(posedge clk); #1; end
        check("abort_no_done", done_c.size(), 0);
        check("abort_no_late_beats", got_w.size(), nbeats);
        host_write(REG_DATA, 32'h1234_5678, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
